regfile_sb: RTL and testbench

Register file with scoreboard: the responder for the decode stage's two read-address/read-data ports and the sink for writeback. It provides two combinational read ports with write-through bypass and one synchronous write port. Per-register pending-write counters give decode a busy indication so it can stall on RAW hazards. x0 is hardwired to zero.

---
 rtl/regfile_sb.sv | 95 +++++++++
 tb/tb_regfile_sb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with write-through bypass and per-register pending-write scoreboard
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en, flush           global enable; clear all pending counters
//   addr1/addr2         read addresses -> data1/data2 (combinational), busy1/busy2
//   claim, claim_addr   decode reserves a destination register
//   wr, addr_rd, data_rd  writeback write port
//   sb_err              sticky: claim hit a saturated counter
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              claim,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr_rd,
    input  logic [DATA_W-1:0] data_rd,
    output logic              sb_err
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [CNT_W-1:0]    cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] inc_v, dec_v;
    logic                we, sat;
    logic                byp1, byp2, hit1, hit2;
    logic [CNT_W-1:0]    c1, c2;

    assign we = en && wr && addr_rd != '0;

    always_comb begin
        inc_v = claim ? NUM_REGS'(1) << claim_addr : '0;
        dec_v = wr ? NUM_REGS'(1) << addr_rd : '0;
        // a claim that coincides with a write to the same register nets to zero and cannot overflow
        sat = en && !flush && claim && claim_addr != '0 &&
              !(wr && addr_rd == claim_addr) && cnt[claim_addr] == CNT_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[addr_rd] <= data_rd;
        end
    end

    // entry 0 is never updated after reset, so its counter stays 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
        end else if (en) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (flush)
                    cnt[r] <= '0;
                else if (inc_v[r] && !dec_v[r] && cnt[r] != CNT_MAX)
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dec_v[r] && !inc_v[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sb_err <= 1'b0;
        else if (sat)
            sb_err <= 1'b1;
    end

    // bypass is suppressed while reset is asserted so reads return 0 throughout reset
    always_comb begin
        byp1  = rst_n && en && wr && addr_rd == addr1;
        byp2  = rst_n && en && wr && addr_rd == addr2;
        c1    = cnt[addr1];
        c2    = cnt[addr2];
        hit1  = byp1 && c1 != '0;
        hit2  = byp2 && c2 != '0;
        data1 = addr1 == '0 ? '0 : byp1 ? data_rd : regs[addr1];
        data2 = addr2 == '0 ? '0 : byp2 ? data_rd : regs[addr2];
        busy1 = addr1 != '0 && (c1 - CNT_W'(hit1)) != '0;
        busy2 = addr2 != '0 && (c2 - CNT_W'(hit2)) != '0;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized check of regfile_sb against a behavioural model
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, flush = 1'b0, claim = 1'b0, wr = 1'b0;
    logic [4:0]  addr1 = '0, addr2 = '0, claim_addr = '0, addr_rd = '0;
    logic [31:0] data_rd = '0;
    logic [31:0] data1, data2;
    logic        busy1, busy2, sb_err;

    int total = 0;
    int bad = 0;

    logic [31:0] m_reg [32];
    int          m_cnt [32];
    logic        m_err;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .addr1(addr1), .addr2(addr2), .data1(data1), .data2(data2),
        .busy1(busy1), .busy2(busy2), .claim(claim), .claim_addr(claim_addr),
        .wr(wr), .addr_rd(addr_rd), .data_rd(data_rd), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (!rst_n || a == 0) return 32'h0;
        if (en && wr && addr_rd == a) return data_rd;
        return m_reg[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a);
        int c;
        c = m_cnt[a];
        if (en && wr && addr_rd == a && c > 0) c--;
        return 32'(rst_n && a != 0 && c != 0);
    endfunction

    // model: values per register, count of in-flight writes per register, sticky error
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] <= 32'h0;
                m_cnt[i] <= 0;
            end
            m_err <= 1'b0;
        end else if (en) begin
            if (wr && addr_rd != 0) m_reg[addr_rd] <= data_rd;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_cnt[i] <= 0;
            end else if (!(claim && wr && claim_addr == addr_rd)) begin
                if (claim && claim_addr != 0) begin
                    if (m_cnt[claim_addr] == 3) m_err <= 1'b1;
                    else m_cnt[claim_addr] <= m_cnt[claim_addr] + 1;
                end
                if (wr && addr_rd != 0 && m_cnt[addr_rd] > 0)
                    m_cnt[addr_rd] <= m_cnt[addr_rd] - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("data1", data1, exp_data(addr1));
        chk("data2", data2, exp_data(addr2));
        chk("busy1", 32'(busy1), exp_busy(addr1));
        chk("busy2", 32'(busy2), exp_busy(addr2));
        chk("sb_err", 32'(sb_err), 32'(rst_n && m_err));
    end

    task automatic drive(input bit e, input bit f, input bit c, input logic [4:0] ca,
                         input bit w, input logic [4:0] ard, input logic [31:0] d,
                         input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #1;
        en = e; flush = f; claim = c; claim_addr = ca;
        wr = w; addr_rd = ard; data_rd = d; addr1 = a1; addr2 = a2;
        #1;
    endtask

    function automatic logic [4:0] rnd_addr();
        return $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            chk("rst_data1", data1, 0);
            chk("rst_busy1", 32'(busy1), 0);
        end
        drive(1, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 5, 0);
        chk("x5_read", data1, 32'hDEADBEEF);
        drive(1, 0, 0, 0, 1, 0, 32'h1234, 0, 0);
        chk("x0_bypass", data1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("x0_read", data1, 0);
        drive(1, 0, 0, 0, 1, 7, 32'hA5A5A5A5, 0, 7);
        chk("bypass", data2, 32'hA5A5A5A5);
        drive(0, 0, 0, 0, 1, 7, 32'h11111111, 0, 7);
        chk("nobypass_en0", data2, 32'hA5A5A5A5);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 7);
        chk("nowrite_en0", data2, 32'hA5A5A5A5);
        drive(1, 0, 1, 3, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 3, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 3, 0);
        chk("x3_busy2", 32'(busy1), 1);
        drive(1, 0, 0, 0, 1, 3, 32'h33, 3, 0);
        chk("x3_wr1", 32'(busy1), 1);
        drive(1, 0, 0, 0, 1, 3, 32'h34, 3, 0);
        chk("x3_wr2", 32'(busy1), 0);
        drive(1, 0, 0, 0, 0, 0, 0, 3, 0);
        chk("x3_idle", 32'(busy1), 0);
        drive(1, 0, 1, 9, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 9, 1, 9, 32'h99, 9, 0);
        chk("x9_simul", 32'(busy1), 0);
        drive(1, 0, 1, 9, 0, 0, 0, 9, 0);
        chk("x9_after", 32'(busy1), 1);
        drive(1, 0, 1, 9, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 9, 0, 0, 0, 0, 0);
        chk("x9_nosat", 32'(sb_err), 0);
        drive(1, 0, 0, 0, 0, 0, 0, 9, 0);
        chk("x9_sat", 32'(sb_err), 1);
        drive(1, 0, 0, 0, 1, 9, 1, 9, 0);
        chk("x9_hold3a", 32'(busy1), 1);
        drive(1, 0, 0, 0, 1, 9, 2, 9, 0);
        chk("x9_hold3b", 32'(busy1), 1);
        drive(1, 0, 0, 0, 1, 9, 3, 9, 0);
        chk("x9_last", 32'(busy1), 0);
        drive(1, 0, 1, 4, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 4, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 4, 32'h55, 4, 0);
        chk("flush_busy", 32'(busy1), 1);
        drive(1, 0, 0, 0, 0, 0, 0, 4, 0);
        chk("flush_cnt", 32'(busy1), 0);
        chk("flush_data", data1, 32'h55);
        drive(1, 0, 0, 0, 1, 4, 32'h66, 4, 0);
        chk("postflush_wr", 32'(busy1), 0);
        drive(1, 0, 0, 0, 0, 0, 0, 4, 0);
        chk("postflush_err", 32'(sb_err), 1);
        chk("postflush_data", data1, 32'h66);
        drive(1, 0, 1, 10, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 10, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 4, 10);
        chk("x10_busy", 32'(busy2), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy2), 0);
        chk("arst_err", 32'(sb_err), 0);
        chk("arst_data", data1, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 4, 10);
        chk("after_rst", data1, 0);
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 4) < 2, rnd_addr(), $urandom_range(0, 4) < 2,
                  rnd_addr(), $urandom, rnd_addr(), rnd_addr());
            rst_n = $urandom_range(0, 299) != 0;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
